act_bitplane_ser: RTL
=====================

// Module: act_bitplane_ser
// PURPOSE
// Bit-serial activation transmitter driving the first-stage accumulator interface (in_ac1/w_and_s/cl_en).
// Accepts one vector of M Pa-bit activations plus an M-bit binary weight mask via valid/ready.
// Emits Pa bit-planes LSB-first, one per cycle, as popcount(plane & mask).
// Generates the accumulator strobes and a done pulse when the accumulator holds the final sum.
// PARAMETERS
// M   16  activations per vector (lanes); the popcount width is $clog2(M)+1
// Pa  8   activation bit width = number of planes per vector; Pa>=1
// PORTS
// clk      in   1                clock; all state changes on rising edge
// rst_n    in   1                synchronous active-low reset
// in_valid in   1                input vector valid
// in_ready out  1                block can accept a vector this cycle
// in_act   in   M*Pa             activation i = in_act[i*Pa +: Pa], unsigned
// in_wgt   in   M                binary weight mask; lane i counts only when in_wgt[i]=1
// flush    in   1                synchronous abort of the vector in flight
// in_ac1   out  $clog2(M)+1      popcount of current plane AND mask, to accumulator
// w_and_s  out  1                accumulator write-and-shift strobe
// cl_en    out  1                accumulator clear/load-select (first plane of a vector)
// ac_done  out  1                one-cycle pulse: accumulator output is final
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state IDLE, plane counter=0, act/wgt regs=0, ac_done=0.
//   While in reset state: in_ac1=0, w_and_s=0, cl_en=0, in_ready=0 during the reset cycle.
// - FSM states: IDLE, SHIFT.
// - IDLE: in_ready=1; w_and_s=0, cl_en=0, in_ac1=0.
//   On in_valid&in_ready: latch in_act/in_wgt, set cnt=0, go to SHIFT.
// - SHIFT, each cycle: in_ac1 = sum over i of (act_reg[i][cnt] & wgt_reg[i]); w_and_s=1.
//   cl_en=1 only when cnt==0; cnt increments by 1.
//   Outputs are combinational from registered state; no extra latency stage.
// - Last plane (cnt==Pa-1): in_ready=1.
//   Accept in the same cycle: reload regs, cnt=0, stay in SHIFT (back-to-back, zero bubble).
//   No accept: go to IDLE.
// - Accept in any other SHIFT cycle is illegal; in_ready=0 there.
// - ac_done is registered: asserted in the cycle after the cycle with cnt==Pa-1 (flush not asserted).
//   At that point the accumulator register holds the sum of (popcount_k << k) for k=0..Pa-1, width $clog2(M)+Pa.
//   With back-to-back vectors, ac_done coincides with cl_en of the next vector.
// - Pa=1: a single SHIFT cycle has cl_en=1 and last-plane behaviour together.
// - flush=1 at an edge:
//   - Next state is IDLE, cnt=0, and ac_done=0 next cycle.
//   - The in-flight vector is discarded.
//   - An in_valid presented in that same cycle is NOT accepted; in_ready is forced to 0 while flush=1.
// - Reset mid-vector: same as flush, but all registers are also cleared.
// - Width rule: the popcount range is 0..M and fits in $clog2(M)+1 bits, so it never saturates.
// TESTING
// - Reset, then idle: in_ready=1, w_and_s=cl_en=ac_done=0, in_ac1=0 for 5 cycles.
// - M=16, Pa=8, all acts 8'hFF, wgt 16'hFFFF:
//   - 8 cycles of in_ac1=16, cl_en only on cycle 0.
//   - ac_done on cycle 8; accumulator value 4080.
// - Acts with lane i = i (0..15), wgt 16'h00FF:
//   - Planes give in_ac1 = 4,4,4,0,0,0,0,0.
//   - Accumulated sum = 28 (0+1+...+7).
// - Two vectors with in_valid held high: second vector's cl_en is in the cycle right after the first vector's last plane.
//   - ac_done pulses in that same cycle; 16 SHIFT cycles with no gap.
// - flush at cnt=3: IDLE next cycle, no ac_done.
//   - A new vector offered while flush=1 is ignored; it is accepted the following cycle.
// - rst_n low at cnt=5: all outputs 0, state IDLE; no ac_done after reset release.

Source files
------------

// File: rtl/act_bitplane_ser.sv
// Bit-serial activation transmitter: streams Pa bit-planes LSB-first as masked popcounts,
// with write-and-shift, clear/load-select and done strobes for the first-stage accumulator.
module act_bitplane_ser #(
  parameter int unsigned M  = 16,
  parameter int unsigned Pa = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [M*Pa-1:0]     in_act,
  input  logic [M-1:0]        in_wgt,
  input  logic                flush,
  output logic [$clog2(M):0]  in_ac1,
  output logic                w_and_s,
  output logic                cl_en,
  output logic                ac_done
);

  localparam int unsigned PopW = $clog2(M) + 1;
  localparam int unsigned CntW = (Pa > 1) ? $clog2(Pa) : 1;

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [M*Pa-1:0]   act_q, act_d;
  logic [M-1:0]      wgt_q, wgt_d;
  logic              done_q, done_d;

  logic              last;
  logic              shifting;
  logic              accept;
  logic [PopW-1:0]   pop;

  // Popcount of bit cnt of every lane, masked by the binary weights.
  always_comb begin
    pop = '0;
    for (int i = 0; i < M; i++) begin
      pop = pop + PopW'(act_q[i*Pa + int'(cnt_q)] & wgt_q[i]);
    end
  end

  // Outputs are forced quiet while reset is held, even mid-vector.
  always_comb begin
    last     = (cnt_q == CntW'(Pa - 1));
    shifting = rst_n && (state_q == StShift);
    in_ready = rst_n && !flush && ((state_q == StIdle) || last);
    w_and_s  = shifting;
    cl_en    = shifting && (cnt_q == '0);
    in_ac1   = shifting ? pop : '0;
    ac_done  = rst_n && done_q;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    wgt_d   = wgt_q;
    done_d  = (state_q == StShift) && last && !flush;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            act_d   = in_act;
            wgt_d   = in_wgt;
            cnt_d   = '0;
            state_d = StShift;
          end
        end
        StShift: begin
          if (last) begin
            cnt_d = '0;
            if (accept) begin
              act_d = in_act;
              wgt_d = in_wgt;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      act_q   <= '0;
      wgt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      wgt_q   <= wgt_d;
      done_q  <= done_d;
    end
  end

endmodule
